// File: rtl/pipe_ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes (also used by the ID decoder)
// and the encoding of the divide-sequencing FSM.
package pipe_ex_stage_pkg;

    localparam logic [3:0] ALU_ADDU = 4'd0;
    localparam logic [3:0] ALU_SUBU = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;
    localparam logic [3:0] ALU_MUL  = 4'd12;
    localparam logic [3:0] ALU_DIVU = 4'd13;
    localparam logic [3:0] ALU_REMU = 4'd14;
    localparam logic [3:0] ALU_DIV  = 4'd15;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_BUSY = 2'd1,
        EX_DONE = 2'd2
    } ex_state_e;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == ALU_DIVU) || (op == ALU_REMU) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/pipe_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, operands loaded on start.
// With a zero divisor it naturally yields an all-ones quotient and remainder = dividend.
module pipe_divider #(
    parameter int DIV_STEPS = 32
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        last_step
);

    localparam int CNT_W = $clog2(DIV_STEPS);

    logic [31:0]      divisor_q;
    logic [CNT_W-1:0] count;
    logic [32:0]      shifted;
    logic             fits;
    logic [31:0]      sub_rem;

    // Shifted partial remainder is 33 bits wide; when it fits, the difference is < divisor.
    always_comb begin
        shifted   = {remainder, quotient[31]};
        fits      = shifted >= {1'b0, divisor_q};
        sub_rem   = shifted[31:0] - divisor_q;
        last_step = count == CNT_W'(DIV_STEPS - 1);
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            quotient  <= '0;
            remainder <= '0;
            divisor_q <= '0;
            count     <= '0;
        end else if (start) begin
            quotient  <= dividend;
            remainder <= '0;
            divisor_q <= divisor;
            count     <= '0;
        end else if (step) begin
            remainder <= fits ? sub_rem : shifted[31:0];
            quotient  <= {quotient[30:0], fits};
            count     <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ex_stage.sv
// Execute stage with EX/MEM register. Single-cycle ALU ops pass straight through; divides
// stall upstream while the iterative divider runs, then write their result from DONE.
module pipe_ex_stage
    import pipe_ex_stage_pkg::*;
#(
    parameter int DIV_STEPS = 32
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic [31:0] in_rs_data,
    input  logic [31:0] in_rt_data,
    input  logic [31:0] in_immed,
    input  logic [31:0] in_shamt,
    input  logic        in_alu_a_sel,
    input  logic        in_alu_b_sel,
    input  logic [3:0]  in_alu_sel,
    input  logic [4:0]  in_rd_waddr,
    input  logic        in_rd_sel,
    input  logic        in_rd_wena,
    input  logic        in_dmem_ena,
    input  logic        in_dmem_wena,
    input  logic [1:0]  in_dmem_type,
    output logic        out_stall_req,
    output logic [31:0] out_alu_result,
    output logic [31:0] out_rt_data,
    output logic [4:0]  out_rd_waddr,
    output logic        out_rd_sel,
    output logic        out_rd_wena,
    output logic        out_dmem_ena,
    output logic        out_dmem_wena,
    output logic [1:0]  out_dmem_type
);

    ex_state_e   state;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        is_div, div_start, a_neg, b_neg;
    logic [31:0] div_dividend, div_divisor;
    logic [31:0] quo_raw, rem_raw, div_result;
    logic        div_last;

    // Operation and controls of the divide in flight, captured at start.
    logic [3:0]  op_q;
    logic        neg_q, zero_q;
    logic [31:0] rt_q;
    logic [4:0]  waddr_q;
    logic        rd_sel_q, rd_wena_q, dmem_ena_q, dmem_wena_q;
    logic [1:0]  dmem_type_q;

    logic [31:0] nxt_result, nxt_rt;
    logic [4:0]  nxt_waddr;
    logic        nxt_rd_sel, nxt_rd_wena, nxt_dmem_ena, nxt_dmem_wena;
    logic [1:0]  nxt_dmem_type;

    always_comb begin
        alu_a = in_alu_a_sel ? in_shamt : in_rs_data;
        alu_b = in_alu_b_sel ? in_immed : in_rt_data;
    end

    always_comb begin
        alu_result = '0;
        case (in_alu_sel)
            ALU_ADDU: alu_result = alu_a + alu_b;
            ALU_SUBU: alu_result = alu_a - alu_b;
            ALU_AND:  alu_result = alu_a & alu_b;
            ALU_OR:   alu_result = alu_a | alu_b;
            ALU_XOR:  alu_result = alu_a ^ alu_b;
            ALU_NOR:  alu_result = ~(alu_a | alu_b);
            ALU_SLT:  alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_result = {31'b0, alu_a < alu_b};
            ALU_SLL:  alu_result = alu_b << alu_a[4:0];
            ALU_SRL:  alu_result = alu_b >> alu_a[4:0];
            ALU_SRA:  alu_result = 32'($signed(alu_b) >>> alu_a[4:0]);
            ALU_LUI:  alu_result = {alu_b[15:0], 16'h0000};
            ALU_MUL:  alu_result = alu_a * alu_b;
            default:  alu_result = '0;
        endcase
    end

    // Only signed DIV takes magnitudes; a divide that writes nothing is a NOP.
    always_comb begin
        is_div        = is_div_op(in_alu_sel);
        div_start     = (state == EX_IDLE) && is_div && in_rd_wena;
        a_neg         = (in_alu_sel == ALU_DIV) && alu_a[31];
        b_neg         = (in_alu_sel == ALU_DIV) && alu_b[31];
        div_dividend  = a_neg ? -alu_a : alu_a;
        div_divisor   = b_neg ? -alu_b : alu_b;
        out_stall_req = in_rst_n && (div_start || (state == EX_BUSY));
    end

    pipe_divider #(
        .DIV_STEPS(DIV_STEPS)
    ) u_divider (
        .in_clk    (in_clk),
        .in_rst_n  (in_rst_n),
        .start     (div_start),
        .step      (state == EX_BUSY),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .quotient  (quo_raw),
        .remainder (rem_raw),
        .last_step (div_last)
    );

    always_comb begin
        if (op_q == ALU_REMU) begin
            div_result = rem_raw;
        end else if (zero_q) begin
            div_result = '1;
        end else begin
            div_result = neg_q ? -quo_raw : quo_raw;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state       <= EX_IDLE;
            op_q        <= '0;
            neg_q       <= 1'b0;
            zero_q      <= 1'b0;
            rt_q        <= '0;
            waddr_q     <= '0;
            rd_sel_q    <= 1'b0;
            rd_wena_q   <= 1'b0;
            dmem_ena_q  <= 1'b0;
            dmem_wena_q <= 1'b0;
            dmem_type_q <= '0;
        end else begin
            case (state)
                EX_IDLE: begin
                    if (div_start) begin
                        state       <= EX_BUSY;
                        op_q        <= in_alu_sel;
                        neg_q       <= a_neg ^ b_neg;
                        zero_q      <= alu_b == '0;
                        rt_q        <= in_rt_data;
                        waddr_q     <= in_rd_waddr;
                        rd_sel_q    <= in_rd_sel;
                        rd_wena_q   <= in_rd_wena;
                        dmem_ena_q  <= in_dmem_ena;
                        dmem_wena_q <= in_dmem_wena;
                        dmem_type_q <= in_dmem_type;
                    end
                end
                EX_BUSY: begin
                    if (div_last) begin
                        state <= EX_DONE;
                    end
                end
                EX_DONE: state <= EX_IDLE;
                default: state <= EX_IDLE;
            endcase
        end
    end

    // EX/MEM next value: bubble unless a single-cycle op is in IDLE or a divide finishes.
    always_comb begin
        nxt_result    = '0;
        nxt_rt        = '0;
        nxt_waddr     = '0;
        nxt_rd_sel    = 1'b0;
        nxt_rd_wena   = 1'b0;
        nxt_dmem_ena  = 1'b0;
        nxt_dmem_wena = 1'b0;
        nxt_dmem_type = '0;
        case (state)
            EX_IDLE: begin
                if (!is_div) begin
                    nxt_result    = alu_result;
                    nxt_rt        = in_rt_data;
                    nxt_waddr     = in_rd_waddr;
                    nxt_rd_sel    = in_rd_sel;
                    nxt_rd_wena   = in_rd_wena;
                    nxt_dmem_ena  = in_dmem_ena;
                    nxt_dmem_wena = in_dmem_wena;
                    nxt_dmem_type = in_dmem_type;
                end
            end
            EX_DONE: begin
                nxt_result    = div_result;
                nxt_rt        = rt_q;
                nxt_waddr     = waddr_q;
                nxt_rd_sel    = rd_sel_q;
                nxt_rd_wena   = rd_wena_q;
                nxt_dmem_ena  = dmem_ena_q;
                nxt_dmem_wena = dmem_wena_q;
                nxt_dmem_type = dmem_type_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_alu_result <= '0;
            out_rt_data    <= '0;
            out_rd_waddr   <= '0;
            out_rd_sel     <= 1'b0;
            out_rd_wena    <= 1'b0;
            out_dmem_ena   <= 1'b0;
            out_dmem_wena  <= 1'b0;
            out_dmem_type  <= '0;
        end else begin
            out_alu_result <= nxt_result;
            out_rt_data    <= nxt_rt;
            out_rd_waddr   <= nxt_waddr;
            out_rd_sel     <= nxt_rd_sel;
            out_rd_wena    <= nxt_rd_wena;
            out_dmem_ena   <= nxt_dmem_ena;
            out_dmem_wena  <= nxt_dmem_wena;
            out_dmem_type  <= nxt_dmem_type;
        end
    end

endmodule

// File: tb/tb_pipe_ex_stage.sv
// Directed bench for pipe_ex_stage: drivers push the expected EX/MEM contents for every
// edge into a queue; a monitor pops and compares shortly after each rising edge.
module tb_pipe_ex_stage;
    import pipe_ex_stage_pkg::*;

    localparam int W = 75;

    logic        in_clk = 1'b0;
    logic        in_rst_n = 1'b1;
    logic [31:0] in_rs_data = '0, in_rt_data = '0, in_immed = '0, in_shamt = '0;
    logic        in_alu_a_sel = 1'b0, in_alu_b_sel = 1'b0;
    logic [3:0]  in_alu_sel = '0;
    logic [4:0]  in_rd_waddr = '0;
    logic        in_rd_sel = 1'b0, in_rd_wena = 1'b0, in_dmem_ena = 1'b0, in_dmem_wena = 1'b0;
    logic [1:0]  in_dmem_type = '0;
    logic        out_stall_req;
    logic [31:0] out_alu_result, out_rt_data;
    logic [4:0]  out_rd_waddr;
    logic        out_rd_sel, out_rd_wena, out_dmem_ena, out_dmem_wena;
    logic [1:0]  out_dmem_type;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_cmp = 0;
    int           n_fail = 0;

    pipe_ex_stage #(.DIV_STEPS(32)) dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_immed(in_immed),
        .in_shamt(in_shamt), .in_alu_a_sel(in_alu_a_sel), .in_alu_b_sel(in_alu_b_sel),
        .in_alu_sel(in_alu_sel), .in_rd_waddr(in_rd_waddr), .in_rd_sel(in_rd_sel),
        .in_rd_wena(in_rd_wena), .in_dmem_ena(in_dmem_ena), .in_dmem_wena(in_dmem_wena),
        .in_dmem_type(in_dmem_type), .out_stall_req(out_stall_req),
        .out_alu_result(out_alu_result), .out_rt_data(out_rt_data),
        .out_rd_waddr(out_rd_waddr), .out_rd_sel(out_rd_sel), .out_rd_wena(out_rd_wena),
        .out_dmem_ena(out_dmem_ena), .out_dmem_wena(out_dmem_wena),
        .out_dmem_type(out_dmem_type)
    );

    // clock / reset
    always #5 in_clk = ~in_clk;

    function automatic logic [W-1:0] pack(input logic [31:0] res, input logic [31:0] rt,
                                          input logic [4:0] waddr, input logic [5:0] ctl);
        return {res, rt, waddr, ctl};
    endfunction

    function automatic logic [W-1:0] actual();
        return {out_alu_result, out_rt_data, out_rd_waddr, out_rd_sel, out_rd_wena,
                out_dmem_ena, out_dmem_wena, out_dmem_type};
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got res=%h rt=%h wa=%0d ctl=%b expected res=%h rt=%h wa=%0d ctl=%b",
                     name, act[74:43], act[42:11], act[10:6], act[5:0],
                     exp[74:43], exp[42:11], exp[10:6], exp[5:0]);
        end
    endtask

    // scoreboard monitor
    always @(posedge in_clk) begin
        #2;
        if (exp_q.size() != 0) begin
            check_vec(name_q.pop_front(), actual(), exp_q.pop_front());
        end
    end

    task automatic apply(input logic [3:0] op, input logic a_sel, input logic b_sel,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                         input logic [31:0] shamt, input logic [4:0] waddr, input logic [5:0] ctl);
        in_alu_sel = op; in_alu_a_sel = a_sel; in_alu_b_sel = b_sel;
        in_rs_data = rs; in_rt_data = rt; in_immed = imm; in_shamt = shamt;
        in_rd_waddr = waddr;
        {in_rd_sel, in_rd_wena, in_dmem_ena, in_dmem_wena, in_dmem_type} = ctl;
    endtask

    // driver: one single-cycle instruction (or a bubble-expected NOP)
    task automatic single(input string name, input logic [3:0] op, input logic a_sel,
                          input logic b_sel, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] imm, input logic [31:0] shamt,
                          input logic [4:0] waddr, input logic [5:0] ctl,
                          input logic [31:0] exp_res, input logic exp_bubble);
        @(negedge in_clk);
        apply(op, a_sel, b_sel, rs, rt, imm, shamt, waddr, ctl);
        #1;
        check_bit({name, "_stall"}, out_stall_req, 1'b0);
        exp_q.push_back(exp_bubble ? '0 : pack(exp_res, rt, waddr, ctl));
        name_q.push_back(name);
    endtask

    // driver: a divide held for its whole stall window, optionally scrambling inputs while busy
    task automatic divide(input string name, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [4:0] waddr, input logic [5:0] ctl,
                          input logic [31:0] exp_res, input logic change);
        for (int k = 0; k <= 33; k++) begin
            @(negedge in_clk);
            if (k == 0) begin
                apply(op, 1'b0, 1'b0, rs, rt, 32'h0, 32'h0, waddr, ctl);
            end else if (k == 1 && change) begin
                apply(ALU_ADDU, 1'b0, 1'b0, 32'hDEADBEEF, 32'h1, 32'h0, 32'h0, 5'd9, 6'b010000);
            end
            #1;
            check_bit($sformatf("%s_stall_c%0d", name, k), out_stall_req, k < 33);
            if (k < 33) begin
                exp_q.push_back('0);
                name_q.push_back({name, "_bubble"});
            end else begin
                exp_q.push_back(pack(exp_res, rt, waddr, ctl));
                name_q.push_back(name);
            end
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge in_clk);
        in_rst_n = 1'b0;
        #1;
        check_vec({name, "_outs"}, actual(), '0);
        check_bit({name, "_stall"}, out_stall_req, 1'b0);
        apply(ALU_ADDU, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 6'b000000);
        @(negedge in_clk);
        in_rst_n = 1'b1;
    endtask

    initial begin
        #1 in_rst_n = 1'b0;
        #2;
        check_vec("por_outs", actual(), '0);
        check_bit("por_stall", out_stall_req, 1'b0);
        repeat (2) @(negedge in_clk);
        in_rst_n = 1'b1;

        // ALU sweep
        single("addu_wrap", ALU_ADDU, 0, 0, 32'hFFFFFFFF, 32'h1, 0, 0, 5'd3, 6'b010000, 32'h0, 0);
        single("subu", ALU_SUBU, 0, 0, 32'h5, 32'h7, 0, 0, 5'd4, 6'b110000, 32'hFFFFFFFE, 0);
        single("and", ALU_AND, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 5'd5, 6'b010000, 32'hF000F000, 0);
        single("or", ALU_OR, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 5'd6, 6'b010000, 32'hFFF0FFF0, 0);
        single("xor", ALU_XOR, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 5'd7, 6'b010000, 32'h0FF00FF0, 0);
        single("nor", ALU_NOR, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 5'd8, 6'b010000, 32'h000F000F, 0);
        single("slt", ALU_SLT, 0, 0, 32'hFFFFFFFF, 32'h1, 0, 0, 5'd10, 6'b010000, 32'h1, 0);
        single("sltu", ALU_SLTU, 0, 0, 32'hFFFFFFFF, 32'h1, 0, 0, 5'd11, 6'b010000, 32'h0, 0);
        single("sll", ALU_SLL, 1, 0, 32'h0, 32'h0000000F, 0, 32'd4, 5'd12, 6'b010000, 32'h000000F0, 0);
        single("srl", ALU_SRL, 1, 0, 32'h0, 32'h80000000, 0, 32'd4, 5'd13, 6'b010000, 32'h08000000, 0);
        single("sra", ALU_SRA, 1, 0, 32'h0, 32'h80000000, 0, 32'd4, 5'd14, 6'b010000, 32'hF8000000, 0);
        single("lui", ALU_LUI, 0, 1, 32'h0, 32'h0, 32'h00001234, 0, 5'd15, 6'b010000, 32'h12340000, 0);
        single("mul", ALU_MUL, 0, 0, 32'h00010001, 32'h00010001, 0, 0, 5'd16, 6'b010000, 32'h00020001, 0);
        single("store", ALU_ADDU, 0, 1, 32'h1000, 32'hCAFEBABE, 32'hFFFFFFFC, 0, 5'd0, 6'b001110, 32'h00000FFC, 0);
        do_reset("rst_mid");
        single("div_nop", ALU_DIVU, 0, 0, 32'd100, 32'd7, 0, 0, 5'd5, 6'b000000, 32'h0, 1);

        // divides
        divide("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 5'd5, 6'b110000, 32'd14, 0);
        divide("remu_100_7", ALU_REMU, 32'd100, 32'd7, 5'd6, 6'b010000, 32'd2, 0);
        divide("div_m7_2", ALU_DIV, 32'hFFFFFFF9, 32'd2, 5'd7, 6'b010000, 32'hFFFFFFFD, 0);
        divide("div_min_m1", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd8, 6'b010000, 32'h80000000, 0);
        divide("divu_9_0", ALU_DIVU, 32'd9, 32'd0, 5'd9, 6'b010000, 32'hFFFFFFFF, 0);
        divide("remu_9_0", ALU_REMU, 32'd9, 32'd0, 5'd10, 6'b010000, 32'd9, 0);
        divide("div_m9_0", ALU_DIV, 32'hFFFFFFF7, 32'd0, 5'd11, 6'b010000, 32'hFFFFFFFF, 0);

        // back-to-back divide then ADDU, with inputs changing while busy
        divide("divu_1000_10", ALU_DIVU, 32'd1000, 32'd10, 5'd12, 6'b110000, 32'd100, 1);
        single("addu_after_div", ALU_ADDU, 0, 0, 32'hDEADBEEF, 32'h1, 0, 0, 5'd9, 6'b010000, 32'hDEADBEF0, 0);

        // reset while the divider is busy
        @(negedge in_clk);
        apply(ALU_DIVU, 1'b0, 1'b0, 32'd100, 32'd7, 32'h0, 32'h0, 5'd5, 6'b010000);
        #1;
        check_bit("abort_start_stall", out_stall_req, 1'b1);
        exp_q.push_back('0);
        name_q.push_back("abort_bubble");
        repeat (5) begin
            @(negedge in_clk);
            #1;
            check_bit("abort_busy_stall", out_stall_req, 1'b1);
            exp_q.push_back('0);
            name_q.push_back("abort_bubble");
        end
        do_reset("rst_busy");
        single("addu_after_abort", ALU_ADDU, 0, 0, 32'd2, 32'd3, 0, 0, 5'd2, 6'b010000, 32'd5, 0);
        for (int i = 0; i < 36; i++) begin
            single("post_abort", ALU_OR, 0, 1, 32'h100, 32'h0, 32'(i), 0, 5'(i), 6'b010000, 32'h100 | 32'(i), 0);
        end

        repeat (3) @(negedge in_clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ex_stage.md
Name: pipe_ex_stage

Overview:
- Execute stage plus EX/MEM pipeline register; consumes the ID/EX register outputs and feeds the MEM stage.
- Single-cycle ALU ops complete in one clock.
- Divide/remainder ops run on an iterative 32-step divider.
- While the divider runs, the block raises out_stall_req so the hazard unit freezes PC, IF/ID and ID/EX, and inserts bubbles into EX/MEM.

Parameters:
- DIV_STEPS, 32, divider iterations; one quotient bit per clock.

Ports:
- in_clk  in  1  clock, rising edge
- in_rst_n  in  1  asynchronous, active-low reset
- in_rs_data  in  32  rs operand
- in_rt_data  in  32  rt operand; also the store data
- in_immed  in  32  extended immediate
- in_shamt  in  32  zero-extended shift amount
- in_alu_a_sel  in  1  1: A = in_shamt; 0: A = in_rs_data
- in_alu_b_sel  in  1  1: B = in_immed; 0: B = in_rt_data
- in_alu_sel  in  4  operation code (see Behaviour)
- in_rd_waddr  in  5  destination register
- in_rd_sel  in  1  writeback source select, passed through
- in_rd_wena  in  1  register write enable
- in_dmem_ena  in  1  memory access enable
- in_dmem_wena  in  1  memory write enable
- in_dmem_type  in  2  access size
- out_stall_req  out  1  combinational; hold upstream stages
- out_alu_result  out  32  registered result
- out_rt_data  out  32  registered store data
- out_rd_waddr, out_rd_sel, out_rd_wena, out_dmem_ena, out_dmem_wena, out_dmem_type  out  5/1/1/1/1/2  registered copies of the inputs

Behaviour:
- Reset: in_clk single clock; in_rst_n asynchronous, active-low. While low, FSM = IDLE, divider state = 0, and every registered output = 0 (result, data, waddr, control, type).
- ALU codes (combinational), 0..11:
  - 0 ADDU, 1 SUBU, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed), 7 SLTU
  - 8 SLL B by A[4:0], 9 SRL, 10 SRA
  - 11 LUI = {B[15:0], 16'b0}
  - All arithmetic is 32-bit wrap with no overflow trap.
- ALU codes 12..15:
  - 12 MUL: low 32 bits of the product, combinational.
  - 13 DIVU quotient, 14 REMU remainder, 15 DIV signed quotient.
- Single-cycle ops (0..12): the EX/MEM register captures the result and pass-through fields on every edge. Latency is 1 clock.
- FSM IDLE/BUSY/DONE, used for codes 13..15:
  - IDLE:
    - A div code with in_rd_wena=1 asserts out_stall_req combinationally in the same cycle.
    - At the edge: latch |A|, |B|, sign flags, opcode, rd_waddr and control fields; count = 0; go to BUSY; EX/MEM loads a bubble (all outputs 0).
    - A div code with in_rd_wena=0 is treated as a NOP: no FSM activity, bubble.
  - BUSY:
    - out_stall_req = 1.
    - One restoring shift-subtract step per edge; count increments.
    - At the edge where count = DIV_STEPS-1, go to DONE.
    - EX/MEM loads a bubble on every BUSY edge.
  - DONE:
    - out_stall_req = 0.
    - The signed quotient is negated if the signs differ.
    - At the edge: EX/MEM captures the result and latched controls, and the FSM returns to IDLE. The inputs are already advancing.
- Divide latency: the start cycle plus 32 BUSY cycles plus the DONE cycle give 34 stall-free-edge equivalents. The result appears on out_alu_result 34 edges after the first stall cycle.
- Divisor = 0:
  - Quotient = 0xFFFFFFFF for DIVU and DIV.
  - Remainder = dividend.
  - The FSM still runs the full length, keeping the timing constant.
- DIV 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, no trap.
- Input changes: while BUSY, changes on the inputs are ignored, because operands and controls were latched at the start.
- Flush: there is no flush input. Branches resolve in ID, so an instruction reaching EX always commits.
- Reset mid-divide: the FSM aborts immediately to IDLE with outputs 0, and no result is written.
- Back-to-back divides: the second divide is seen in IDLE on the cycle after DONE and starts normally.

Decomposition:
- Shared package: the ALU opcode constants (ALU_ADDU..ALU_DIV) and the FSM state encoding. The ID decoder must use the same package.
- Natural sub-module: pipe_divider. It holds the iterative unsigned core: start/busy/done, |A|, |B| in; quotient and remainder out. The stage handles sign fix-up, the zero-divisor case, muxing and the EX/MEM register.

Test Plan:
- Reset: hold in_rst_n=0 mid-stream -> all outputs 0 and out_stall_req=0. Assert reset during BUSY -> immediate IDLE, no result written.
- ALU sweep:
  - ADDU 0xFFFFFFFF+1 -> 0x00000000.
  - SLT 0xFFFFFFFF vs 1 -> 1; SLTU -> 0.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - LUI imm 0x1234 -> 0x12340000.
  - Each result appears 1 edge later.
- DIVU 100/7, rd=5:
  - out_stall_req high for 33 cycles, with bubbles during that time.
  - Then out_alu_result=14 and out_rd_waddr=5.
  - REMU on the same operands gives 2.
- DIV -7/2 -> 0xFFFFFFFD. DIV 0x80000000/-1 -> 0x80000000.
- Divide by zero: DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9; same stall length.
- Back-to-back DIVU then ADDU:
  - Changing the inputs during BUSY does not corrupt the quotient.
  - The ADDU result follows exactly one edge after the DIVU result.
